w2_layer_sequencer: RTL

Sequences one fully-connected layer pass over the 512-entry w2 weight ROM (32 outputs x 16 inputs, row-major, 32-bit IEEE-754 words). It generates ROM and activation-buffer addresses, pairs each weight with its activation, and streams the pairs to a downstream floating-point MAC over a valid/ready handshake. Row-boundary flags tell the MAC when to clear and when to emit its accumulator. It sits between the layer-1 activation buffer, the w2 ROM and the shared FP MAC unit, and the top-level inference FSM starts it.

---
 rtl/w2_layer_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/w2_layer_sequencer.sv
// Streams the w2 weight ROM against the layer-1 activations as (weight, act) pairs
// to the shared FP MAC, flagging the first and last column of every output row.
module w2_layer_sequencer #(
    parameter int unsigned IN_DIM     = 16,
    parameter int unsigned OUT_DIM    = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      rom_addr,
    input  logic [DATA_WIDTH-1:0]      rom_weight,
    output logic [$clog2(IN_DIM)-1:0]  act_addr,
    input  logic [DATA_WIDTH-1:0]      act_data,
    output logic                       mac_valid,
    input  logic                       mac_ready,
    output logic [DATA_WIDTH-1:0]      mac_weight,
    output logic [DATA_WIDTH-1:0]      mac_act,
    output logic                       mac_first,
    output logic                       mac_last,
    output logic [$clog2(OUT_DIM)-1:0] mac_row
);
    localparam int unsigned COL_W = $clog2(IN_DIM);
    localparam int unsigned ROW_W = $clog2(OUT_DIM);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_DIM - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_DIM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                 state_q;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic                   busy_q, done_q, valid_q, first_q, last_q;
    logic [ROW_W-1:0]       row_out_q;
    logic [DATA_WIDTH-1:0]  weight_q, act_q;
    logic                   load, handshake, last_pair;

    assign handshake = valid_q && mac_ready;
    assign load      = (state_q == RUN) && (!valid_q || mac_ready);
    assign last_pair = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Row-major layout with power-of-two dims: the address is just {row, col}.
    assign rom_addr = {row_q, col_q};
    assign act_addr = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q + 1'b1;
        if (col_q == COL_LAST) begin
            row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            row_out_q <= '0;
            weight_q  <= '0;
            act_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            row_q   <= '0;
                            col_q   <= '0;
                        end
                    end
                    RUN: begin
                        // A load also retires the pair being handed off this cycle.
                        if (load) begin
                            valid_q   <= 1'b1;
                            weight_q  <= rom_weight;
                            act_q     <= act_data;
                            first_q   <= (col_q == '0);
                            last_q    <= (col_q == COL_LAST);
                            row_out_q <= row_q;
                            if (last_pair) begin
                                state_q <= DRAIN;
                                row_q   <= '0;
                                col_q   <= '0;
                            end else begin
                                row_q <= row_d;
                                col_q <= col_d;
                            end
                        end
                    end
                    DRAIN: begin
                        if (handshake) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mac_valid  = valid_q;
    assign mac_weight = weight_q;
    assign mac_act    = act_q;
    assign mac_first  = first_q;
    assign mac_last   = last_q;
    assign mac_row    = row_out_q;
endmodule
